// File: rtl/bram_lsu_port_if.sv
// Bundle of the core-side load/store handshake and the BRAM port signals.
// The master modport is the load/store unit; the slave modport is the
// core plus attached BRAM seen from the environment.
interface bram_lsu_port_if #(
  parameter int RAM_DEPTH = 8192
);

  // Number of bits needed to index depth values (Xilinx-style clogb2)
  function automatic int clogb2(input int depth);
    int d_v;
    int r_v;
    d_v = depth;
    r_v = 0;
    while (d_v > 0) begin
      r_v = r_v + 1;
      d_v = d_v >>> 1;
    end
    return r_v;
  endfunction

  localparam int AW = clogb2(RAM_DEPTH - 1);

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;
  logic          mem_regce;
  logic          mem_rst;
  logic [31:0]   mem_dout;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output mem_en, mem_we, mem_addr, mem_din, mem_regce, mem_rst,
    input  mem_dout
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  mem_en, mem_we, mem_addr, mem_din, mem_regce, mem_rst,
    output mem_dout
  );

endinterface

// File: rtl/bram_lsu_port.sv
// Load/store unit front end driving one single-clock BRAM port.
// One access in flight; memory is driven combinationally in the accept
// cycle so the BRAM samples on the accept edge. Loads are formatted
// (sign/zero extension) when the BRAM data becomes valid.
module bram_lsu_port #(
  parameter int    RAM_DEPTH       = 8192,
  parameter string RAM_PERFORMANCE = "LOW_LATENCY"
) (
  input  logic             clk,
  input  logic             rst,
  bram_lsu_port_if.master  bus
);

  // Number of bits needed to index depth values (Xilinx-style clogb2)
  function automatic int clogb2(input int depth);
    int d_v;
    int r_v;
    d_v = depth;
    r_v = 0;
    while (d_v > 0) begin
      r_v = r_v + 1;
      d_v = d_v >>> 1;
    end
    return r_v;
  endfunction

  localparam int          AW      = clogb2(RAM_DEPTH - 1);
  localparam logic [31:0] DEPTH_W = 32'(RAM_DEPTH);
  localparam bit          HP      = (RAM_PERFORMANCE == "HIGH_PERFORMANCE");

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  // Byte-lane write mask for a store of the given size at the given offset
  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicate right-aligned store data across every lane it may land in
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] w);
    case (f3[1:0])
      2'b00:   return {4{w[7:0]}};
      2'b01:   return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  // Extract the addressed byte/half from a BRAM word and extend it
  function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] d);
    logic [7:0]  b_v;
    logic [15:0] h_v;
    b_v = 8'(d >> {off, 3'b000});
    h_v = off[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  return {{24{b_v[7]}}, b_v};
      3'b001:  return {{16{h_v[15]}}, h_v};
      3'b010:  return d;
      3'b100:  return {24'h000000, b_v};
      3'b101:  return {16'h0000, h_v};
      default: return 32'h0000_0000;
    endcase
  endfunction

  state_t      state_r;
  state_t      state_s;
  logic        req_ready_s;
  logic        accept_s;
  logic        legal_s;
  logic        misalign_s;
  logic        range_err_s;
  logic        err_s;
  logic [2:0]  f3_r;
  logic [1:0]  off_r;
  logic        rsp_valid_r;
  logic [31:0] rsp_rdata_r;
  logic        rsp_err_r;

  assign req_ready_s = (state_r == ST_IDLE) && !rst;
  assign accept_s    = bus.req_valid && req_ready_s;

  // Request decode: legality, alignment and address range
  always_comb begin
    legal_s     = 1'b0;
    misalign_s  = 1'b0;
    range_err_s = 1'b0;
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: legal_s = 1'b1;
      3'b100, 3'b101:         legal_s = !bus.req_we;
      default:                legal_s = 1'b0;
    endcase
    case (bus.req_funct3[1:0])
      2'b01:   misalign_s = bus.req_addr[0];
      2'b10:   misalign_s = (bus.req_addr[1:0] != 2'b00);
      default: misalign_s = 1'b0;
    endcase
    if ({2'b00, bus.req_addr[31:2]} >= DEPTH_W) begin
      range_err_s = 1'b1;
    end else begin
      range_err_s = 1'b0;
    end
    err_s = !legal_s || misalign_s || range_err_s;
  end

  assign bus.req_ready = req_ready_s;
  assign bus.mem_en    = accept_s && !err_s;
  assign bus.mem_we    = (accept_s && !err_s && bus.req_we) ?
                         store_mask(bus.req_funct3, bus.req_addr[1:0]) : 4'b0000;
  assign bus.mem_addr  = bus.req_addr[AW+1:2];
  assign bus.mem_din   = store_data(bus.req_funct3, bus.req_wdata);
  assign bus.mem_regce = (state_r == ST_WAIT) && !rst;
  assign bus.mem_rst   = rst;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;

  // Next-state logic: errors and stores answer immediately, loads wait on the BRAM
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (err_s || bus.req_we) begin
            state_s = ST_RESP;
          end else if (HP) begin
            state_s = ST_WAIT;
          end else begin
            state_s = ST_CAPTURE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT:    state_s = ST_CAPTURE;
      ST_CAPTURE: state_s = ST_RESP;
      ST_RESP: begin
        if (rsp_valid_r && bus.rsp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default:    state_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Capture the load size/sign code and byte offset at accept
  always_ff @(posedge clk) begin
    if (rst) begin
      f3_r  <= 3'b000;
      off_r <= 2'b00;
    end else if (accept_s) begin
      f3_r  <= bus.req_funct3;
      off_r <= bus.req_addr[1:0];
    end
  end

  // Response register: set at accept (store/error) or capture (load), held until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end else if (accept_s && (err_s || bus.req_we)) begin
      rsp_valid_r <= 1'b1;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= err_s;
    end else if (state_r == ST_CAPTURE) begin
      rsp_valid_r <= 1'b1;
      rsp_rdata_r <= load_fmt(f3_r, off_r, bus.mem_dout);
      rsp_err_r   <= 1'b0;
    end else if ((state_r == ST_RESP) && rsp_valid_r && bus.rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bram_lsu_port.sv
// Directed bench for bram_lsu_port: one LOW_LATENCY and one HIGH_PERFORMANCE
// instance, each attached to a small read-first BRAM model.
module tb_bram_lsu_port;

  logic        clk;
  logic        rst;
  logic        sel_hp;
  logic        t_valid;
  logic        t_we;
  logic [2:0]  t_f3;
  logic [31:0] t_addr;
  logic [31:0] t_wdata;
  logic        t_rsp_ready;
  int          total;
  int          bad;

  bram_lsu_port_if #(.RAM_DEPTH(8192)) ll_if ();
  bram_lsu_port_if #(.RAM_DEPTH(8192)) hp_if ();

  bram_lsu_port #(.RAM_DEPTH(8192), .RAM_PERFORMANCE("LOW_LATENCY")) u_ll (
    .clk(clk), .rst(rst), .bus(ll_if)
  );
  bram_lsu_port #(.RAM_DEPTH(8192), .RAM_PERFORMANCE("HIGH_PERFORMANCE")) u_hp (
    .clk(clk), .rst(rst), .bus(hp_if)
  );

  assign ll_if.req_valid  = t_valid && !sel_hp;
  assign hp_if.req_valid  = t_valid && sel_hp;
  assign ll_if.req_we     = t_we;
  assign hp_if.req_we     = t_we;
  assign ll_if.req_funct3 = t_f3;
  assign hp_if.req_funct3 = t_f3;
  assign ll_if.req_addr   = t_addr;
  assign hp_if.req_addr   = t_addr;
  assign ll_if.req_wdata  = t_wdata;
  assign hp_if.req_wdata  = t_wdata;
  assign ll_if.rsp_ready  = t_rsp_ready;
  assign hp_if.rsp_ready  = t_rsp_ready;

  // BRAM models: read-first, byte write enables; HP adds an output register
  logic [31:0] ll_mem [0:8191];
  logic [31:0] ll_dout;
  logic [31:0] hp_mem [0:8191];
  logic [31:0] hp_lat;
  logic [31:0] hp_out;

  always @(posedge clk) begin
    if (ll_if.mem_en) begin
      ll_dout <= ll_mem[ll_if.mem_addr];
      for (int i = 0; i < 4; i++) begin
        if (ll_if.mem_we[i]) ll_mem[ll_if.mem_addr][8*i +: 8] <= ll_if.mem_din[8*i +: 8];
      end
    end
  end

  always @(posedge clk) begin
    if (hp_if.mem_en) begin
      hp_lat <= hp_mem[hp_if.mem_addr];
      for (int j = 0; j < 4; j++) begin
        if (hp_if.mem_we[j]) hp_mem[hp_if.mem_addr][8*j +: 8] <= hp_if.mem_din[8*j +: 8];
      end
    end
    if (hp_if.mem_rst) hp_out <= 32'h0000_0000;
    else if (hp_if.mem_regce) hp_out <= hp_lat;
  end

  assign ll_if.mem_dout = ll_dout;
  assign hp_if.mem_dout = hp_out;

  logic        o_req_ready;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic        o_mem_en;
  logic [3:0]  o_mem_we;
  logic [31:0] o_mem_din;
  logic        o_mem_regce;
  logic        o_mem_rst;

  assign o_req_ready = sel_hp ? hp_if.req_ready : ll_if.req_ready;
  assign o_rsp_valid = sel_hp ? hp_if.rsp_valid : ll_if.rsp_valid;
  assign o_rsp_rdata = sel_hp ? hp_if.rsp_rdata : ll_if.rsp_rdata;
  assign o_rsp_err   = sel_hp ? hp_if.rsp_err   : ll_if.rsp_err;
  assign o_mem_en    = sel_hp ? hp_if.mem_en    : ll_if.mem_en;
  assign o_mem_we    = sel_hp ? hp_if.mem_we    : ll_if.mem_we;
  assign o_mem_din   = sel_hp ? hp_if.mem_din   : ll_if.mem_din;
  assign o_mem_regce = sel_hp ? hp_if.mem_regce : ll_if.mem_regce;
  assign o_mem_rst   = sel_hp ? hp_if.mem_rst   : ll_if.mem_rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request from IDLE through its response; starts and ends at posedge+1
  task automatic run_req(input string tag, input logic hp, input logic we,
                         input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic een,
                         input logic [3:0] ewe, input logic [31:0] edin,
                         input int elat, input logic eerr,
                         input logic [31:0] erdata, input int eregce, input int hold);
    int lat;
    int regce_n;
    sel_hp  = hp;
    t_we    = we;
    t_f3    = f3;
    t_addr  = addr;
    t_wdata = wdata;
    t_valid = 1'b1;
    @(negedge clk);
    chk({tag, ".req_ready"}, 32'(o_req_ready), 32'h1);
    chk({tag, ".mem_en"}, 32'(o_mem_en), 32'(een));
    chk({tag, ".mem_we"}, 32'(o_mem_we), 32'(ewe));
    if (we) chk({tag, ".mem_din"}, o_mem_din, edin);
    regce_n = int'(o_mem_regce);
    @(posedge clk);
    #1;
    t_valid = 1'b0;
    lat = 0;
    while (lat < 8) begin
      @(negedge clk);
      lat = lat + 1;
      regce_n = regce_n + int'(o_mem_regce);
      if (o_rsp_valid) break;
      @(posedge clk);
      #1;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(elat));
    chk({tag, ".rsp_rdata"}, o_rsp_rdata, erdata);
    chk({tag, ".rsp_err"}, 32'(o_rsp_err), 32'(eerr));
    chk({tag, ".regce_cycles"}, 32'(regce_n), 32'(eregce));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk({tag, ".hold_valid"}, 32'(o_rsp_valid), 32'h1);
      chk({tag, ".hold_rdata"}, o_rsp_rdata, erdata);
      chk({tag, ".hold_err"}, 32'(o_rsp_err), 32'(eerr));
      chk({tag, ".hold_ready"}, 32'(o_req_ready), 32'h0);
    end
    t_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    t_rsp_ready = 1'b0;
    @(negedge clk);
    chk({tag, ".ready_after"}, 32'(o_req_ready), 32'h1);
    chk({tag, ".valid_after"}, 32'(o_rsp_valid), 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    sel_hp      = 1'b0;
    t_valid     = 1'b0;
    t_we        = 1'b0;
    t_f3        = 3'b000;
    t_addr      = 32'h0000_0000;
    t_wdata     = 32'h0000_0000;
    t_rsp_ready = 1'b0;

    // Reset state, with a store presented that must not reach memory
    repeat (2) @(posedge clk);
    #1;
    t_valid = 1'b1;
    t_we    = 1'b1;
    t_f3    = 3'b010;
    t_addr  = 32'h0000_0100;
    t_wdata = 32'h5555_5555;
    @(negedge clk);
    chk("rst.req_ready", 32'(o_req_ready), 32'h0);
    chk("rst.rsp_valid", 32'(o_rsp_valid), 32'h0);
    chk("rst.rsp_rdata", o_rsp_rdata, 32'h0);
    chk("rst.rsp_err", 32'(o_rsp_err), 32'h0);
    chk("rst.mem_en", 32'(o_mem_en), 32'h0);
    chk("rst.mem_we", 32'(o_mem_we), 32'h0);
    chk("rst.mem_regce", 32'(o_mem_regce), 32'h0);
    chk("rst.mem_rst", 32'(o_mem_rst), 32'h1);
    chk("rst.hp_req_ready", 32'(hp_if.req_ready), 32'h0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    t_valid = 1'b0;
    @(negedge clk);
    chk("rel.req_ready", 32'(o_req_ready), 32'h1);
    chk("rel.mem_rst", 32'(o_mem_rst), 32'h0);
    @(posedge clk);
    #1;

    // LOW_LATENCY: word store then load
    run_req("sw100", 1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b1, 4'hF, 32'hDEADBEEF, 1, 1'b0, 32'h0, 0, 0);
    run_req("lw100", 1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 1'b1, 4'h0, 32'h0, 2, 1'b0, 32'hDEADBEEF, 0, 0);
    // Byte store and byte/word loads
    run_req("sb101", 1'b0, 1'b1, 3'b000, 32'h101, 32'h00000080, 1'b1, 4'b0010, 32'h80808080, 1, 1'b0, 32'h0, 0, 0);
    run_req("lb101", 1'b0, 1'b0, 3'b000, 32'h101, 32'h0, 1'b1, 4'h0, 32'h0, 2, 1'b0, 32'hFFFFFF80, 0, 0);
    run_req("lbu101", 1'b0, 1'b0, 3'b100, 32'h101, 32'h0, 1'b1, 4'h0, 32'h0, 2, 1'b0, 32'h00000080, 0, 0);
    run_req("lw100b", 1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 1'b1, 4'h0, 32'h0, 2, 1'b0, 32'hDEAD80EF, 0, 0);
    // Upper halfword store and signed/unsigned halfword loads
    run_req("sh106", 1'b0, 1'b1, 3'b001, 32'h106, 32'hFFFF8001, 1'b1, 4'b1100, 32'h80018001, 1, 1'b0, 32'h0, 0, 0);
    run_req("lh106", 1'b0, 1'b0, 3'b001, 32'h106, 32'h0, 1'b1, 4'h0, 32'h0, 2, 1'b0, 32'hFFFF8001, 0, 0);
    run_req("lhu106", 1'b0, 1'b0, 3'b101, 32'h106, 32'h0, 1'b1, 4'h0, 32'h0, 2, 1'b0, 32'h00008001, 0, 0);
    // Error cases: no memory access, 1-cycle error response
    run_req("lh103", 1'b0, 1'b0, 3'b001, 32'h103, 32'h0, 1'b0, 4'h0, 32'h0, 1, 1'b1, 32'h0, 0, 0);
    run_req("sw102", 1'b0, 1'b1, 3'b010, 32'h102, 32'h11111111, 1'b0, 4'h0, 32'h11111111, 1, 1'b1, 32'h0, 0, 0);
    run_req("ld011", 1'b0, 1'b0, 3'b011, 32'h100, 32'h0, 1'b0, 4'h0, 32'h0, 1, 1'b1, 32'h0, 0, 0);
    run_req("sw_f3_100", 1'b0, 1'b1, 3'b100, 32'h100, 32'h22222222, 1'b0, 4'h0, 32'h22222222, 1, 1'b1, 32'h0, 0, 0);
    run_req("lw8000", 1'b0, 1'b0, 3'b010, 32'h8000, 32'h0, 1'b0, 4'h0, 32'h0, 1, 1'b1, 32'h0, 0, 0);
    run_req("sw8000", 1'b0, 1'b1, 3'b010, 32'h8000, 32'h33333333, 1'b0, 4'h0, 32'h33333333, 1, 1'b1, 32'h0, 0, 0);
    // Last in-range word is legal
    run_req("sw7ffc", 1'b0, 1'b1, 3'b010, 32'h7FFC, 32'hA5A5A5A5, 1'b1, 4'hF, 32'hA5A5A5A5, 1, 1'b0, 32'h0, 0, 0);
    run_req("lw7ffc", 1'b0, 1'b0, 3'b010, 32'h7FFC, 32'h0, 1'b1, 4'h0, 32'h0, 2, 1'b0, 32'hA5A5A5A5, 0, 0);
    // Memory unchanged by the rejected requests
    run_req("lw100c", 1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 1'b1, 4'h0, 32'h0, 2, 1'b0, 32'hDEAD80EF, 0, 0);

    // HIGH_PERFORMANCE: store, then halfword load through the output register
    run_req("hp_sw100", 1'b1, 1'b1, 3'b010, 32'h100, 32'h1234ABCD, 1'b1, 4'hF, 32'h1234ABCD, 1, 1'b0, 32'h0, 0, 0);
    run_req("hp_lhu102", 1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 1'b1, 4'h0, 32'h0, 3, 1'b0, 32'h00001234, 1, 0);
    run_req("hp_lb100", 1'b1, 1'b0, 3'b000, 32'h100, 32'h0, 1'b1, 4'h0, 32'h0, 3, 1'b0, 32'hFFFFFFCD, 1, 0);

    // Backpressure: response held for 5 cycles
    run_req("bp_lw100", 1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 1'b1, 4'h0, 32'h0, 2, 1'b0, 32'hDEAD80EF, 0, 5);

    // Reset during the CAPTURE cycle of a load
    sel_hp  = 1'b0;
    t_we    = 1'b0;
    t_f3    = 3'b010;
    t_addr  = 32'h0000_0100;
    t_valid = 1'b1;
    @(negedge clk);
    chk("mrst.accept_ready", 32'(o_req_ready), 32'h1);
    @(posedge clk);
    #1;
    t_valid = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    chk("mrst.ready_in_rst", 32'(o_req_ready), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst.valid_dropped", 32'(o_rsp_valid), 32'h0);
    chk("mrst.ready_after", 32'(o_req_ready), 32'h1);
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("mrst.no_spurious", 32'(o_rsp_valid), 32'h0);
    end
    @(posedge clk);
    #1;
    run_req("mrst_lw100", 1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 1'b1, 4'h0, 32'h0, 2, 1'b0, 32'hDEAD80EF, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
